// File: rtl/bb_cdc_handshake_tx.sv
// bb_cdc_handshake_tx
//   Sending end of a req/ack clock-domain crossing. Takes one word from a
//   valid/ready producer, holds it on data_out, raises the request toward
//   the far domain, and waits for the resynchronised acknowledge.
//
//   Build option: BB_CDC_TX_FOUR_PHASE_EN
//     undefined : 2-phase toggle protocol (req_out toggles once per word)
//     defined   : 4-phase return-to-zero protocol (req_out pulses 0->1->0)
//
// Ports
//   clk, rst_n          source clock, async active-low reset
//   src_valid/src_ready producer handshake; src_ready == (state == IDLE)
//   src_data  [DW]      word offered by the producer
//   req_out             registered request to the far domain
//   data_out  [DW]      registered word, stable while a transfer is in flight
//   ack_in              far-domain acknowledge (asynchronous to clk)
//   done                one-cycle pulse, first cycle back in IDLE
//   proto_err           sticky: ack moved while nothing was in flight
module bb_cdc_handshake_tx #(
  parameter int            DW         = 8,
  parameter int            SYNC_STAGE = 2,
  parameter logic [DW-1:0] RST_VAL    = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic [DW-1:0] src_data,
  output logic          req_out,
  output logic [DW-1:0] data_out,
  input  logic          ack_in,
  output logic          done,
  output logic          proto_err
);

`ifdef BB_CDC_TX_FOUR_PHASE_EN
  typedef enum logic [1:0] {IDLE, WAIT_ACK_HI, WAIT_ACK_LO} state_t;
`else
  typedef enum logic {IDLE, WAIT_ACK} state_t;
`endif

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [DW-1:0]   data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [SYNC_STAGE-1:0] sync_q;
  logic            ack_sync;
  logic            accept;
  logic            idle_bad;

  // ack_in synchroniser; only the last flop is used by the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGE-2:0], ack_in};
  end
  assign ack_sync = sync_q[SYNC_STAGE-1];

  assign src_ready = (state_q == IDLE);
  assign accept    = src_valid && src_ready;

`ifdef BB_CDC_TX_FOUR_PHASE_EN
  // at rest both wires sit low
  assign idle_bad = ack_sync;
`else
  // at rest ack mirrors the last request level
  assign idle_bad = (ack_sync != req_q);
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (idle_bad) err_d = 1'b1;
        if (accept) begin
          data_d = src_data;
`ifdef BB_CDC_TX_FOUR_PHASE_EN
          req_d   = 1'b1;
          state_d = WAIT_ACK_HI;
`else
          req_d   = ~req_q;
          state_d = WAIT_ACK;
`endif
        end
      end
`ifdef BB_CDC_TX_FOUR_PHASE_EN
      WAIT_ACK_HI: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_sync) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`else
      WAIT_ACK: begin
        if (ack_sync == req_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= RST_VAL;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_out   = req_q;
  assign data_out  = data_q;
  assign done      = done_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_bb_cdc_handshake_tx.sv
// Bench for bb_cdc_handshake_tx (either protocol build).
// The reference model tracks the transfer at the level of protocol events:
// which word is in flight, what level req_out should have, and the cycle
// on which done must appear (ack change + SYNC_STAGE + 1).
module tb_bb_cdc_handshake_tx;
  localparam int            DW = 8;
  localparam int            S  = 2;
  localparam logic [DW-1:0] RV = 8'h00;
`ifdef BB_CDC_TX_FOUR_PHASE_EN
  localparam bit FOUR = 1'b1;
`else
  localparam bit FOUR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, src_valid, src_ready, req_out, ack_in, done, proto_err;
  logic [DW-1:0] src_data, data_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DW-1:0] cur;
  logic          req_exp;
  logic [DW-1:0] words[$];

  always #5 clk = ~clk;

  bb_cdc_handshake_tx #(.DW(DW), .SYNC_STAGE(S), .RST_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .req_out(req_out), .data_out(data_out),
    .ack_in(ack_in), .done(done), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset(input string w);
    chk({w, ".req"},   32'(req_out),   32'(1'b0));
    chk({w, ".data"},  32'(data_out),  32'(RV));
    chk({w, ".ready"}, 32'(src_ready), 32'(1'b1));
    chk({w, ".done"},  32'(done),      32'(1'b0));
    chk({w, ".err"},   32'(proto_err), 32'(1'b0));
  endtask

  task automatic do_reset(input string w);
    rst_n = 1'b0; src_valid = 1'b0; src_data = '0; ack_in = 1'b0;
    #1;
    chk_reset(w);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur = RV; req_exp = 1'b0;
    tick();
    chk_reset({w, "_rel"});
  endtask

  // Sends every word in 'words'. dly_fix >= 0: bench acks that many cycles
  // after it sees the request change; < 0: random 0..6. gaps: random idle
  // cycles on src_valid; otherwise src_valid stays high while words remain.
  task automatic run_xfers(input int dly_fix, input bit gaps);
    int n = words.size();
    int idx = 0, ndone = 0, budget = 0, dly = 0, ph = 0;
    int ack_at = -1, lo_due = -1, done_due = -1;
    bit busy = 1'b0, accept, done_exp;
    logic [DW-1:0] w;
    while (ndone < n && budget < 3000) begin
      if (busy) begin
        if (!gaps && idx < n) begin src_valid = 1'b1; src_data = words[idx]; end
        else begin src_valid = 1'($urandom_range(0, 1)); src_data = DW'($urandom); end
      end else if (idx < n) begin
        src_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        src_data  = src_valid ? words[idx] : DW'($urandom);
      end else begin
        src_valid = 1'b0; src_data = DW'($urandom);
      end
      accept = src_valid && !busy;
      w = src_data;
      tick(); budget++;
      if (accept) begin
        cur = w; idx++; busy = 1'b1; ph = 0;
        req_exp = FOUR ? 1'b1 : ~req_exp;
        dly = (dly_fix >= 0) ? dly_fix : int'($urandom_range(0, 6));
        ack_at = cyc + dly;
      end
      if (cyc == lo_due) begin
        req_exp = 1'b0; lo_due = -1; ph = 1; ack_at = cyc + dly;
      end
      done_exp = (cyc == done_due);
      if (done_exp) begin busy = 1'b0; ndone++; done_due = -1; end
      chk("req",   32'(req_out),   32'(req_exp));
      chk("data",  32'(data_out),  32'(cur));
      chk("ready", 32'(src_ready), 32'(!busy));
      chk("done",  32'(done),      32'(done_exp));
      chk("err",   32'(proto_err), 32'(1'b0));
      // far-domain responder
      if (busy && cyc == ack_at) begin
        ack_at = -1;
        if (!FOUR)        begin ack_in = req_exp; done_due = cyc + S + 1; end
        else if (ph == 0) begin ack_in = 1'b1;    lo_due   = cyc + S + 1; end
        else              begin ack_in = 1'b0;    done_due = cyc + S + 1; end
      end
    end
    chk("all_done", 32'(ndone), 32'(n));
    src_valid = 1'b0;
    tick();
    chk("done_single", 32'(done),      32'(1'b0));
    chk("ready_after", 32'(src_ready), 32'(1'b1));
    chk("req_after",   32'(req_out),   32'(req_exp));
  endtask

  initial begin
    do_reset("por");

    words = '{8'hA5};
    run_xfers(2, 1'b0);

    words = '{8'h11, 8'h22};
    run_xfers(5, 1'b0);

    words.delete();
    for (int i = 0; i < 25; i++) words.push_back(DW'($urandom));
    run_xfers(-1, 1'b1);

    // ack moves while idle: sticky error after S+1 edges
    do_reset("pre_err");
    ack_in = 1'b1;
    for (int i = 1; i <= S; i++) begin
      tick();
      chk("err_early", 32'(proto_err), 32'(1'b0));
    end
    tick();
    chk("err_set", 32'(proto_err), 32'(1'b1));
    ack_in = 1'b0;
    repeat (2 * S + 2) tick();
    chk("err_sticky", 32'(proto_err), 32'(1'b1));
    chk("err_ready",  32'(src_ready), 32'(1'b1));

    // reset in the middle of a transfer
    src_valid = 1'b1; src_data = 8'h5A;
    tick();
    src_valid = 1'b0;
    chk("mid_req",   32'(req_out),   32'(1'b1));
    chk("mid_data",  32'(data_out),  32'(8'h5A));
    chk("mid_ready", 32'(src_ready), 32'(1'b0));
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    #3;
    rst_n = 1'b1;
    cur = RV; req_exp = 1'b0;
    tick();
    chk_reset("mid_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
